// File: rtl/passive_close_server.sv
// Server-side passive-close engine: ACKs the peer FIN, waits for the local close, then sends FIN and retransmits it until ACKed.
// Optional PASSIVE_CLOSE_DUP_FIN_EN: a duplicate peer FIN in CLOSE_WAIT re-sends the ACK.
module passive_close_server #(
    parameter int               SEQ_W      = 8,
    parameter logic [SEQ_W-1:0] ISS        = 8'h40,
    parameter logic [SEQ_W-1:0] IRS        = 8'h10,
    parameter int               RTO_CYCLES = 16,
    parameter int               MAX_RETX   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic             rx_fin,
    input  logic             rx_ack,
    input  logic [SEQ_W-1:0] rx_seq,
    input  logic [SEQ_W-1:0] rx_ack_no,
    input  logic             app_close,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_fin,
    output logic             tx_ack,
    output logic [SEQ_W-1:0] tx_seq,
    output logic [SEQ_W-1:0] tx_ack_no,
    output logic [2:0]       state,
    output logic             closed,
    output logic             abort
);
    typedef enum logic [2:0] {
        ESTAB      = 3'b101,
        ACK_FIN    = 3'b001,
        CLOSE_WAIT = 3'b110,
        SEND_FIN   = 3'b010,
        LAST_ACK   = 3'b111,
        CLOSED     = 3'b000
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             fin;
        logic             ack;
        logic [SEQ_W-1:0] seq;
        logic [SEQ_W-1:0] ack_no;
    } tx_seg_t;

    localparam int             TW       = $clog2(RTO_CYCLES + 1);
    localparam int             RW       = $clog2(MAX_RETX + 1);
    localparam logic [TW-1:0]  RTO_LD   = TW'(RTO_CYCLES);
    localparam logic [RW-1:0]  RETX_MAX = RW'(MAX_RETX);

    state_t           state_q, state_d;
    tx_seg_t          tx_q, tx_d;
    logic [SEQ_W-1:0] snd_q, snd_d, rcv_q, rcv_d, snd_inc, rcv_inc;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retx_q, retx_d;
    logic             closed_q, closed_d, abort_q, abort_d;
    logic             hs, fin_hit, ack_hit;
`ifdef PASSIVE_CLOSE_DUP_FIN_EN
    logic [SEQ_W-1:0] rcv_dec;
    logic             dup_fin;
`endif

    always_comb begin
        snd_inc = snd_q + 1'b1;
        rcv_inc = rcv_q + 1'b1;
        hs      = tx_q.valid & tx_ready;
        fin_hit = rx_valid & rx_fin & (rx_seq == rcv_q);
        ack_hit = rx_valid & rx_ack & (rx_ack_no == snd_inc);
`ifdef PASSIVE_CLOSE_DUP_FIN_EN
        rcv_dec = rcv_q - 1'b1;
        dup_fin = rx_valid & rx_fin & (rx_seq == rcv_dec);
`endif

        state_d  = state_q;
        snd_d    = snd_q;
        rcv_d    = rcv_q;
        timer_d  = timer_q;
        retx_d   = retx_q;
        closed_d = 1'b0;
        abort_d  = 1'b0;

        case (state_q)
            ESTAB: if (fin_hit) begin
                rcv_d   = rcv_inc;
                state_d = ACK_FIN;
            end
            ACK_FIN: if (hs) state_d = CLOSE_WAIT;
            CLOSE_WAIT: begin
`ifdef PASSIVE_CLOSE_DUP_FIN_EN
                // A repeated FIN means our ACK was lost; answer it before closing.
                if (dup_fin)        state_d = ACK_FIN;
                else if (app_close) state_d = SEND_FIN;
`else
                if (app_close)      state_d = SEND_FIN;
`endif
            end
            SEND_FIN: if (hs) begin
                timer_d = RTO_LD;
                retx_d  = retx_q + 1'b1;
                state_d = LAST_ACK;
            end
            LAST_ACK: begin
                // ACK takes priority over an expiring timer.
                if (ack_hit) begin
                    snd_d    = snd_inc;
                    closed_d = 1'b1;
                    state_d  = CLOSED;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (retx_q < RETX_MAX) begin
                    state_d = SEND_FIN;
                end else begin
                    abort_d = 1'b1;
                    state_d = CLOSED;
                end
            end
            default: ;
        endcase

        // Outputs are registered from the next state so they line up with it.
        tx_d.valid  = (state_d == ACK_FIN) || (state_d == SEND_FIN);
        tx_d.fin    = (state_d == SEND_FIN);
        tx_d.ack    = tx_d.valid;
        tx_d.seq    = snd_d;
        tx_d.ack_no = rcv_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ESTAB;
            snd_q    <= ISS;
            rcv_q    <= IRS;
            timer_q  <= '0;
            retx_q   <= '0;
            closed_q <= 1'b0;
            abort_q  <= 1'b0;
            tx_q     <= '{valid: 1'b0, fin: 1'b0, ack: 1'b0, seq: ISS, ack_no: IRS};
        end else begin
            state_q  <= state_d;
            snd_q    <= snd_d;
            rcv_q    <= rcv_d;
            timer_q  <= timer_d;
            retx_q   <= retx_d;
            closed_q <= closed_d;
            abort_q  <= abort_d;
            tx_q     <= tx_d;
        end
    end

    assign state     = state_q;
    assign tx_valid  = tx_q.valid;
    assign tx_fin    = tx_q.fin;
    assign tx_ack    = tx_q.ack;
    assign tx_seq    = tx_q.seq;
    assign tx_ack_no = tx_q.ack_no;
    assign closed    = closed_q;
    assign abort     = abort_q;
endmodule

// File: doc/passive_close_server.md
# passive_close_server

Server-side passive-close engine for the client/server connection model. Starts in the established state; on the peer's FIN it sends an ACK, waits for the local application to close, sends its own FIN, and waits for the final ACK with retransmission. It is the responder to the client's active close and sits after the server handshake FSM. The transmit segment port uses a valid/ready handshake.

## Interface
- SEQ_W, 8 — sequence/ack number width.
- ISS, 8'h40 — local send sequence number at reset.
- IRS, 8'h10 — expected peer sequence number at reset.
- RTO_CYCLES, 16 — retransmit timeout in clock cycles (≥1).
- MAX_RETX, 3 — FIN transmissions allowed before abort (≥1).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  incoming segment present this cycle (single-cycle, no backpressure).
- rx_fin  in  1  incoming segment carries FIN.
- rx_ack  in  1  incoming segment carries ACK.
- rx_seq  in  SEQ_W  incoming sequence number.
- rx_ack_no  in  SEQ_W  incoming acknowledgement number.
- app_close  in  1  application close request; level-sampled.
- tx_valid  out  1  outgoing segment valid.
- tx_ready  in  1  downstream accepts segment.
- tx_fin, tx_ack  out  1  outgoing flags.
- tx_seq, tx_ack_no  out  SEQ_W  outgoing numbers.
- state  out  3  current state encoding.
- closed  out  1  one-cycle pulse on graceful close.
- abort  out  1  one-cycle pulse on retransmit exhaustion.

## Operation
- States/encodings: ESTAB 3'b101, ACK_FIN 3'b001, CLOSE_WAIT 3'b110, SEND_FIN 3'b010, LAST_ACK 3'b111, CLOSED 3'b000.
- Registers: snd_nxt (reset ISS), rcv_nxt (reset IRS), timer, retx_cnt (reset 0). All arithmetic mod 2^SEQ_W.
- ESTAB: rx_valid & rx_fin & rx_seq==rcv_nxt → rcv_nxt+1, go ACK_FIN. FIN with another seq is ignored. app_close is ignored.
- ACK_FIN: tx_valid=1, tx_ack=1, tx_fin=0, tx_seq=snd_nxt, tx_ack_no=rcv_nxt. On tx_valid&tx_ready, go CLOSE_WAIT.
- CLOSE_WAIT: app_close=1 → SEND_FIN.
- SEND_FIN: tx_valid=1, tx_fin=1, tx_ack=1, tx_seq=snd_nxt, tx_ack_no=rcv_nxt. On handshake: timer←RTO_CYCLES, retx_cnt+1, go LAST_ACK.
- LAST_ACK: rx_valid & rx_ack & rx_ack_no==snd_nxt+1 → snd_nxt+1, closed pulse, go CLOSED. Otherwise:
  - timer≠0: decrement timer.
  - timer==0 and retx_cnt<MAX_RETX: go SEND_FIN (same seq).
  - timer==0 and retx_cnt==MAX_RETX: abort pulse, go CLOSED.
- CLOSED: terminal. All rx input is ignored. Exit only by reset.
- tx_valid, once asserted, holds with stable fields until tx_ready.

## Timing
- Reset values: tx_valid=0, tx_fin=0, tx_ack=0, tx_seq=ISS, tx_ack_no=IRS, state=3'b101, closed=0, abort=0.
- All outputs are registered.
- Latencies:
  - Valid FIN at edge N → tx_valid=1 in the cycle after edge N.
  - app_close seen in CLOSE_WAIT at edge N → FIN tx_valid after edge N.
  - FIN handshake at edge H, no ACK → SEND_FIN entered after edge H+RTO_CYCLES+1.
- Same-cycle ACK and timer==0: ACK wins, giving closed, not retransmit.
- ACK arriving while in SEND_FIN is ignored.
- closed/abort are asserted for exactly one cycle, registered with the CLOSED entry.
- Reset assertion at any point (including mid-handshake with tx_valid=1) immediately forces reset values. The segment is dropped.

## Configuration
- PASSIVE_CLOSE_DUP_FIN_EN defined: in CLOSE_WAIT, a duplicate FIN re-sends the ACK by returning to ACK_FIN, with rcv_nxt unchanged.
  - Duplicate FIN: rx_valid & rx_fin & rx_seq==rcv_nxt−1.
- Not defined: duplicate FINs are ignored in all states.

## Test plan
- Graceful close (defaults): FIN seq 8'h10.
  - ACK with ack_no 8'h11, seq 8'h40.
  - app_close → FIN seq 8'h40.
  - ACK ack_no 8'h41 → closed pulse, state 3'b000.
- Bad FIN: FIN seq 8'h12 in ESTAB → state stays 3'b101, tx_valid stays 0.
- Backpressure: tx_ready=0 for 5 cycles during ACK_FIN → tx_valid/tx_ack/tx_ack_no stable; single handshake, then CLOSE_WAIT.
- No ACK: RTO_CYCLES=4, MAX_RETX=3 → three FIN transmissions, each with seq 8'h40; abort pulse; state 3'b000; closed never asserted.
- Same-cycle ACK and timeout: valid ACK on the timer==0 cycle → closed pulse, no retransmit. Wrap case: ISS=8'hFF, expected ack_no 8'h00.
- Mid-operation reset: reset low in LAST_ACK → immediate state 3'b101, tx_valid=0. With PASSIVE_CLOSE_DUP_FIN_EN, a repeat FIN 8'h10 in CLOSE_WAIT re-sends ACK 8'h11.
